// File: rtl/viterbi_traceback_pkg.sv
// ============================================================================
// viterbi_traceback_pkg
// Shared widths and the traceback FSM state type for the Viterbi traceback.
// Revision: 1.0
// ============================================================================
`default_nettype none

package viterbi_traceback_pkg;

  localparam int MAX_STATE_REG_NUM = 8;
  localparam int MAX_STATE_NUM     = 2 ** MAX_STATE_REG_NUM;
  localparam int SURV_W            = 2 * MAX_STATE_NUM;
  localparam int MAX_STEPS         = 160;
  localparam int STEP_CNT_W        = $clog2(MAX_STEPS);
  localparam int MAX_DATA_BITS     = 2 * MAX_STEPS;

  typedef enum logic [1:0] {
    WRITE = 2'd0,
    TRACE = 2'd1,
    DONE  = 2'd2
  } tb_state_t;

endpackage

`default_nettype wire

// File: rtl/viterbi_surv_mem.sv
// ============================================================================
// viterbi_surv_mem
// Survivor-decision store: one row per trellis step, async full-word read.
// Revision: 1.0
// ============================================================================
`default_nettype none

module viterbi_surv_mem #(
  parameter int DEPTH = 160,
  parameter int WIDTH = 512,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

`default_nettype wire

// File: rtl/viterbi_traceback.sv
// ============================================================================
// viterbi_traceback
// Stores per-step survivors, then traces back from the best end state.
// Revision: 1.0
// ============================================================================
`default_nettype none

module viterbi_traceback
  import viterbi_traceback_pkg::*;
#(
  parameter int STATE_REG_NUM = MAX_STATE_REG_NUM,
  parameter int STEPS         = MAX_STEPS,
  parameter int DATA_BITS     = MAX_DATA_BITS
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en_tb,
  input  logic                       i_surv_valid,
  input  logic [2*(2**STATE_REG_NUM)-1:0] i_surv,
  input  logic [STATE_REG_NUM-1:0]   i_best_state,
  output logic [DATA_BITS-1:0]       o_decoded_data,
  output logic                       o_decoded_done,
  output logic                       o_busy
);

  localparam int STATE_NUM = 2 ** STATE_REG_NUM;
  localparam int SW        = 2 * STATE_NUM;
  localparam int CNT_W     = $clog2(STEPS);
  localparam int IDX_W     = $clog2(DATA_BITS);

  tb_state_t                state_q;
  logic [CNT_W-1:0]         wr_cnt_q;
  logic [CNT_W-1:0]         tb_cnt_q;
  logic [STATE_REG_NUM-1:0] cur_state_q;
  logic [DATA_BITS-1:0]     data_q;
  logic                     done_q;
  logic                     busy_q;

  logic                     mem_we;
  logic [SW-1:0]            rd_word;
  logic [STATE_REG_NUM:0]   sel_idx;
  logic [1:0]               surv_pair;
  logic [IDX_W-1:0]         bit_idx;

  assign mem_we = rst & en_tb & i_surv_valid & (state_q == WRITE);

  viterbi_surv_mem #(
    .DEPTH (STEPS),
    .WIDTH (SW),
    .AW    (CNT_W)
  ) u_surv_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (wr_cnt_q),
    .wdata_i (i_surv),
    .raddr_i (tb_cnt_q),
    .rdata_o (rd_word)
  );

  // Pair s of the survivor word holds the MSB pair the encoder shifted out
  assign sel_idx   = {cur_state_q, 1'b0};
  assign surv_pair = rd_word[sel_idx +: 2];
  assign bit_idx   = IDX_W'(DATA_BITS - 2 - 2 * int'(tb_cnt_q));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= WRITE;
      wr_cnt_q    <= '0;
      tb_cnt_q    <= '0;
      cur_state_q <= '0;
      data_q      <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else if (en_tb) begin
      case (state_q)
        WRITE: begin
          if (i_surv_valid) begin
            if (wr_cnt_q == CNT_W'(STEPS - 1)) begin
              cur_state_q <= i_best_state;
              tb_cnt_q    <= CNT_W'(STEPS - 1);
              busy_q      <= 1'b1;
              state_q     <= TRACE;
            end else begin
              wr_cnt_q <= wr_cnt_q + CNT_W'(1);
            end
          end
        end
        TRACE: begin
          // Low state bits are the two info bits this step shifted in
          data_q[bit_idx +: 2] <= cur_state_q[1:0];
          cur_state_q          <= {surv_pair, cur_state_q[STATE_REG_NUM-1:2]};
          if (tb_cnt_q == '0) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            tb_cnt_q <= tb_cnt_q - CNT_W'(1);
          end
        end
        DONE: begin
          state_q <= DONE;
        end
        default: begin
          state_q <= WRITE;
        end
      endcase
    end
  end

  assign o_decoded_data = data_q;
  assign o_decoded_done = done_q;
  assign o_busy         = busy_q;

endmodule

`default_nettype wire
